// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per
// clock, LSB digit first, through one DIGIT-bit ripple slice with a registered
// carry linking consecutive digits. Valid/ready handshake on both sides.
module digit_serial_addsub #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   // Operand width must split into whole digits.
   generate
      if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
         $error("digit_serial_addsub: WIDTH must be a positive multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;
   logic [WIDTH-1:0] r_s;
   logic             r_carry;
   logic             r_cout;
   logic             r_ovf;
   logic             r_out_valid;

   logic [DIGIT-1:0] w_da;
   logic [DIGIT-1:0] w_db;
   logic [DIGIT-1:0] w_sum;
   logic [DIGIT:0]   w_c;
   logic             w_last;
   int               w_base;

   // Select the digit currently being processed.
   assign w_base = int'(r_cnt) * DIGIT;
   assign w_da   = r_opa[w_base +: DIGIT];
   assign w_db   = r_opb[w_base +: DIGIT];
   assign w_last = (r_cnt == CW'(NDIG - 1));

   // Ripple chain of full-adder cells; the carry reg feeds the LSB cell.
   assign w_c[0] = r_carry;
   generate
      for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
         assign w_sum[gi]  = w_da[gi] ^ w_db[gi] ^ w_c[gi];
         assign w_c[gi+1]  = (w_da[gi] & w_db[gi]) | (w_c[gi] & (w_da[gi] ^ w_db[gi]));
      end
   endgenerate

   // Control FSM with registered result, flags and output valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_opa       <= '0;
         r_opb       <= '0;
         r_carry     <= 1'b0;
         r_s         <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  // Subtraction is a + ~b + ~cin: invert b and the carry-in.
                  r_opa   <= a;
                  r_opb   <= sub ? ~b : b;
                  r_carry <= cin ^ sub;
                  r_cnt   <= '0;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_s[w_base +: DIGIT] <= w_sum;
               r_carry              <= w_c[DIGIT];
               r_cnt                <= r_cnt + 1'b1;
               if (w_last) begin
                  // Carry into and out of the MSB cell give the signed overflow.
                  r_cout      <= w_c[DIGIT];
                  r_ovf       <= w_c[DIGIT] ^ w_c[DIGIT-1];
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);
   assign out_valid = r_out_valid;
   assign s         = r_s;
   assign cout      = r_cout;
   assign ovf       = r_ovf;

endmodule
